sound_arbiter: RTL and testbench

Shares the single note-playing sound engine (the unit that drives `buzzer` from octave/note/length and reports `over`) between three requesters: free-play key hits, learn-mode prompts and autoplay playback. A fixed-priority arbiter latches the winning request, issues one start pulse to the engine and tracks the engine's busy/over status until the note finishes. It then returns a done or aborted pulse to the owner and enforces a configurable silent gap before the next note. Free-play may preempt the two lower-priority requesters so that live key presses are never delayed by playback.

---
 rtl/sound_arbiter_if.sv | 31 +++
 rtl/sound_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sound_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sound_arbiter_if.sv
// Connection bundle between the sound arbiter, its three requesters and the note engine.
// The arbiter uses the slave view; requesters plus engine together form the master view.
interface sound_arbiter_if #(
  parameter int OCT_W  = 3,
  parameter int NOTE_W = 4,
  parameter int LEN_W  = 3
);
  logic [2:0]          req;
  logic [3*OCT_W-1:0]  oct_in;
  logic [3*NOTE_W-1:0] note_in;
  logic [3*LEN_W-1:0]  len_in;
  logic                sd_over;
  logic                sd_start;
  logic [OCT_W-1:0]    sd_octave;
  logic [NOTE_W-1:0]   sd_note;
  logic [LEN_W-1:0]    sd_length;
  logic [2:0]          grant;
  logic [2:0]          done;
  logic [2:0]          aborted;
  logic                busy;

  modport slave (
    input  req, oct_in, note_in, len_in, sd_over,
    output sd_start, sd_octave, sd_note, sd_length, grant, done, aborted, busy
  );

  modport master (
    output req, oct_in, note_in, len_in, sd_over,
    input  sd_start, sd_octave, sd_note, sd_length, grant, done, aborted, busy
  );
endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one note engine between free-play, learn and autoplay.
// Free-play may abort lower-priority notes; a silent gap separates completed notes.
module sound_arbiter #(
  parameter int OCT_W   = 3,
  parameter int NOTE_W  = 4,
  parameter int LEN_W   = 3,
  parameter int GAP_CYC = 0,
  parameter int ACK_TO  = 4,
  parameter int PREEMPT = 1
) (
  input logic           clk,
  input logic           rst,
  sound_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_PLAY     = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  localparam logic [7:0] ACK_LOAD = 8'(ACK_TO);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC);

  state_t            state_r, state_s;
  logic [2:0]        grant_r, grant_s;
  logic [2:0]        done_r, done_s;
  logic [2:0]        aborted_r, aborted_s;
  logic              start_r, start_s;
  logic              busy_r, busy_s;
  logic [OCT_W-1:0]  oct_r, oct_s;
  logic [NOTE_W-1:0] note_r, note_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [7:0]        ack_r, ack_s;
  logic [7:0]        gap_r, gap_s;
  logic              preempt_s;
  logic              finish_s;
  int                pick_s;

  // Next-state, payload latch and pulse generation.
  always_comb begin
    state_s   = state_r;
    grant_s   = grant_r;
    done_s    = 3'b000;
    aborted_s = 3'b000;
    start_s   = 1'b0;
    oct_s     = oct_r;
    note_s    = note_r;
    len_s     = len_r;
    ack_s     = ack_r;
    gap_s     = gap_r;
    finish_s  = 1'b0;

    if (bus.req[0]) begin
      pick_s = 0;
    end else if (bus.req[1]) begin
      pick_s = 1;
    end else begin
      pick_s = 2;
    end

    preempt_s = (PREEMPT != 0) && bus.req[0] && (grant_r[1] || grant_r[2]) &&
                ((state_r == ST_START) || (state_r == ST_WAIT_ACK) || (state_r == ST_PLAY));

    if (preempt_s) begin
      aborted_s = grant_r;
      grant_s   = 3'b001;
      oct_s     = bus.oct_in[OCT_W-1:0];
      note_s    = bus.note_in[NOTE_W-1:0];
      len_s     = bus.len_in[LEN_W-1:0];
      start_s   = 1'b1;
      state_s   = ST_START;
    end else begin
      case (state_r)
        // A done pulse still on the bus marks the completion cycle; arbitration waits one more cycle.
        ST_IDLE: begin
          if ((bus.req != 3'b000) && (done_r == 3'b000)) begin
            grant_s = 3'(3'b001 << pick_s);
            oct_s   = bus.oct_in[pick_s*OCT_W +: OCT_W];
            note_s  = bus.note_in[pick_s*NOTE_W +: NOTE_W];
            len_s   = bus.len_in[pick_s*LEN_W +: LEN_W];
            start_s = 1'b1;
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_START: begin
          ack_s   = ACK_LOAD;
          state_s = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!bus.sd_over) begin
            state_s = ST_PLAY;
          end else if (ack_r <= 8'd1) begin
            finish_s = 1'b1;
          end else begin
            ack_s = ack_r - 8'd1;
          end
        end
        ST_PLAY: begin
          if (bus.sd_over) begin
            finish_s = 1'b1;
          end else begin
            state_s = ST_PLAY;
          end
        end
        ST_GAP: begin
          if (gap_r == 8'd0) begin
            state_s = ST_IDLE;
          end else begin
            gap_s = gap_r - 8'd1;
          end
        end
        default: begin
          state_s = ST_IDLE;
          grant_s = 3'b000;
        end
      endcase

      if (finish_s) begin
        done_s  = grant_r;
        grant_s = 3'b000;
        gap_s   = GAP_LOAD;
        state_s = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
      end else begin
        done_s = 3'b000;
      end
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 3'b000;
      done_r    <= 3'b000;
      aborted_r <= 3'b000;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
      oct_r     <= '0;
      note_r    <= '0;
      len_r     <= '0;
      ack_r     <= 8'd0;
      gap_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      grant_r   <= grant_s;
      done_r    <= done_s;
      aborted_r <= aborted_s;
      start_r   <= start_s;
      busy_r    <= busy_s;
      oct_r     <= oct_s;
      note_r    <= note_s;
      len_r     <= len_s;
      ack_r     <= ack_s;
      gap_r     <= gap_s;
    end
  end

  assign bus.sd_start  = start_r;
  assign bus.sd_octave = oct_r;
  assign bus.sd_note   = note_r;
  assign bus.sd_length = len_r;
  assign bus.grant     = grant_r;
  assign bus.done      = done_r;
  assign bus.aborted   = aborted_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_sound_arbiter.sv
// Random requesters and a random note engine drive two arbiters (gap 3 with preemption,
// gap 0 without); a timestamp-based model predicts every output each cycle.
module tb_sound_arbiter;
  localparam int OW = 3;
  localparam int NW = 4;
  localparam int LW = 3;
  localparam int PW = OW + NW + LW;
  localparam int ACK = 4;
  localparam int GAP_A = 3;
  localparam int GAP_B = 0;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sound_arbiter_if #(.OCT_W(OW), .NOTE_W(NW), .LEN_W(LW)) bus_a ();
  sound_arbiter_if #(.OCT_W(OW), .NOTE_W(NW), .LEN_W(LW)) bus_b ();

  sound_arbiter #(.OCT_W(OW), .NOTE_W(NW), .LEN_W(LW), .GAP_CYC(GAP_A), .ACK_TO(ACK), .PREEMPT(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sound_arbiter #(.OCT_W(OW), .NOTE_W(NW), .LEN_W(LW), .GAP_CYC(GAP_B), .ACK_TO(ACK), .PREEMPT(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [2:0]      req_v  [2];
  logic [3*OW-1:0] oct_v  [2];
  logic [3*NW-1:0] note_v [2];
  logic [3*LW-1:0] len_v  [2];
  logic            ov_v   [2];
  logic [2:0]      grant_o[2], done_o[2], abort_o[2];
  logic            start_o[2], busy_o[2];
  logic [PW-1:0]   pay_o  [2];

  assign bus_a.req = req_v[0];   assign bus_b.req = req_v[1];
  assign bus_a.oct_in = oct_v[0];   assign bus_b.oct_in = oct_v[1];
  assign bus_a.note_in = note_v[0]; assign bus_b.note_in = note_v[1];
  assign bus_a.len_in = len_v[0];   assign bus_b.len_in = len_v[1];
  assign bus_a.sd_over = ov_v[0];   assign bus_b.sd_over = ov_v[1];
  assign grant_o[0] = bus_a.grant;   assign grant_o[1] = bus_b.grant;
  assign done_o[0] = bus_a.done;     assign done_o[1] = bus_b.done;
  assign abort_o[0] = bus_a.aborted; assign abort_o[1] = bus_b.aborted;
  assign start_o[0] = bus_a.sd_start; assign start_o[1] = bus_b.sd_start;
  assign busy_o[0] = bus_a.busy;     assign busy_o[1] = bus_b.busy;
  assign pay_o[0] = {bus_a.sd_octave, bus_a.sd_note, bus_a.sd_length};
  assign pay_o[1] = {bus_b.sd_octave, bus_b.sd_note, bus_b.sd_length};

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: owner, whether a note is in flight, and absolute cycle stamps.
  int            owner_m[2], t_start_m[2], quiet_m[2], done_at_m[2];
  bit            live_m[2], acked_m[2];
  logic [PW-1:0] pay_m[2];
  logic [2:0]    e_grant[2], e_done[2], e_abort[2];
  logic          e_start[2], e_busy[2];

  // Random engine per DUT: ack delay, play length, occasionally never acks.
  int eng_ph[2], eng_w[2], eng_p[2];
  int n_abort = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic int lowest(input logic [2:0] r);
    for (int i = 0; i < 3; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [PW-1:0] slice_pay(input int k, input int i);
    logic [3*OW-1:0] o;
    logic [3*NW-1:0] n;
    logic [3*LW-1:0] l;
    o = oct_v[k]; n = note_v[k]; l = len_v[k];
    return {o[i*OW +: OW], n[i*NW +: NW], l[i*LW +: LW]};
  endfunction

  task automatic finish_note(input int k, input int c, input int gap);
    e_done[k]    = 3'(1 << owner_m[k]);
    live_m[k]    = 1'b0;
    done_at_m[k] = c;
    quiet_m[k]   = c + gap + 2;
  endtask

  task automatic model_step(input int k, input int c);
    int gap;
    bit pre;
    gap = (k == 0) ? GAP_A : GAP_B;
    pre = (k == 0);
    e_done[k] = 3'b000; e_abort[k] = 3'b000; e_start[k] = 1'b0;
    if (rst) begin
      live_m[k] = 1'b0; owner_m[k] = -1; pay_m[k] = '0;
      quiet_m[k] = 0; done_at_m[k] = -100;
    end else if (live_m[k]) begin
      if (pre && req_v[k][0] && owner_m[k] != 0) begin
        e_abort[k] = 3'(1 << owner_m[k]);
        if (k == 0) n_abort++;
        owner_m[k] = 0; pay_m[k] = slice_pay(k, 0);
        e_start[k] = 1'b1; t_start_m[k] = c; acked_m[k] = 1'b0;
      end else if (acked_m[k] && ov_v[k]) begin
        finish_note(k, c, gap);
      end else if (!acked_m[k] && !ov_v[k] && c >= t_start_m[k] + 2) begin
        acked_m[k] = 1'b1;
      end else if (!acked_m[k] && ov_v[k] && c == t_start_m[k] + 1 + ACK) begin
        finish_note(k, c, gap);
      end
    end else if (c >= quiet_m[k] && req_v[k] != 3'b000) begin
      owner_m[k] = lowest(req_v[k]);
      pay_m[k] = slice_pay(k, owner_m[k]);
      live_m[k] = 1'b1; acked_m[k] = 1'b0; t_start_m[k] = c; e_start[k] = 1'b1;
    end
    e_grant[k] = live_m[k] ? 3'(1 << owner_m[k]) : 3'b000;
    e_busy[k]  = live_m[k] || (gap > 0 && !rst && c <= done_at_m[k] + gap);
  endtask

  task automatic drive_engine(input int k);
    if (start_o[k]) begin
      ov_v[k] = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        eng_ph[k] = 0;
      end else begin
        eng_ph[k] = 1; eng_w[k] = $urandom_range(0, 2); eng_p[k] = $urandom_range(1, 12);
      end
    end else begin
      case (eng_ph[k])
        1: if (eng_w[k] == 0) begin ov_v[k] = 1'b0; eng_ph[k] = 2; end else eng_w[k]--;
        2: if (eng_p[k] == 0) begin ov_v[k] = 1'b1; eng_ph[k] = 0; end else eng_p[k]--;
        default: ov_v[k] = 1'b1;
      endcase
    end
  endtask

  task automatic drive_req(input int k);
    for (int i = 0; i < 3; i++) begin
      if (!req_v[k][i]) begin
        if ($urandom_range(0, (i == 0) ? 30 : 5) == 0) req_v[k][i] = 1'b1;
      end else if (grant_o[k][i]) begin
        if ($urandom_range(0, 3) != 0) req_v[k][i] = 1'b0;
      end
    end
    oct_v[k]  = 9'($urandom);
    note_v[k] = 12'($urandom);
    len_v[k]  = 9'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 3'b000; oct_v[k] = '0; note_v[k] = '0; len_v[k] = '0; ov_v[k] = 1'b1;
      eng_ph[k] = 0; eng_w[k] = 0; eng_p[k] = 0;
      live_m[k] = 1'b0; owner_m[k] = -1; quiet_m[k] = 0; done_at_m[k] = -100;
    end
    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) model_step(k, cyc);
      #1;
      for (int k = 0; k < 2; k++) begin
        check_val($sformatf("grant%0d", k), 32'(grant_o[k]), 32'(e_grant[k]));
        check_val($sformatf("done%0d", k), 32'(done_o[k]), 32'(e_done[k]));
        check_val($sformatf("aborted%0d", k), 32'(abort_o[k]), 32'(e_abort[k]));
        check_val($sformatf("sd_start%0d", k), 32'(start_o[k]), 32'(e_start[k]));
        check_val($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(e_busy[k]));
        check_val($sformatf("payload%0d", k), 32'(pay_o[k]), 32'(pay_m[k]));
      end
      rst = (n < 3) || ($urandom_range(0, 399) == 0);
      for (int k = 0; k < 2; k++) begin
        drive_engine(k);
        drive_req(k);
      end
    end
    check_val("preempt_seen", 32'(n_abort > 0), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
